intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of interrupt sources (1..16).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h40000040, byte base of the 32-byte register window.
REQ-003 SHALL have port sysclk  input  1  clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rd  input  1  single-cycle read strobe.
REQ-006 SHALL have port wr  input  1  single-cycle write strobe.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  combinational read data.
REQ-010 SHALL have port src  input  N_SRC  asynchronous interrupt request lines.
REQ-011 SHALL have port kmode  input  1  CPU in kernel mode (PC[31]); blocks irq.
REQ-012 SHALL have port irq  output  1  interrupt request to the CPU.

Function
REQ-013 SHALL pass each src bit through a 2-flop synchronizer (s2) plus a third history flop (s3).
REQ-014 SHALL map registers at BASE_ADDR offsets: 0x00 PEND, 0x04 MASK, 0x08 MODE, 0x0C CLAIM, 0x10 EOI, 0x14 INSVC; all use bits [N_SRC-1:0], upper bits read 0.
REQ-015 SHALL, when MODE[i]=1 (edge), set PEND[i] on s2[i]&~s3[i]; PEND[i] then holds until cleared.
REQ-016 SHALL, when MODE[i]=0 (level), make PEND[i] equal s2[i] every cycle; clears have no effect.
REQ-017 SHALL, on wr to PEND, clear edge-mode bits where wdata=1 (W1C); a same-cycle new edge wins over the clear.
REQ-018 SHALL make MASK and MODE plain read/write; a MODE change takes effect next cycle, PEND[i] cleared on the edge of that write.
REQ-019 SHALL define ACT = PEND & MASK; winner = lowest-index set bit of ACT (index 0 highest priority).
REQ-020 SHALL read CLAIM as winner index + 1, or 0 when ACT is zero.
REQ-021 SHALL, on rd of CLAIM with ACT nonzero and no source in service, latch INSVC = winner id + 1 and clear PEND[winner] if edge-mode.
REQ-022 SHALL make a CLAIM read while INSVC is nonzero, or with ACT zero, return the value per REQ-020 with no state change.
REQ-023 SHALL, on wr to EOI, clear INSVC to 0 regardless of wdata; EOI with INSVC=0 has no effect.
REQ-024 SHALL drive irq = (ACT != 0) & (INSVC == 0) & ~kmode, combinationally from registered state.
REQ-025 SHALL return rdata = 0 when rd is low or addr is outside the window or at offsets 0x18/0x1C (OR-ed bus).
REQ-026 SHALL ignore writes to CLAIM, INSVC, 0x18, 0x1C and outside the window.
REQ-027 SHALL decode addr[4:2] for the register and compare addr[31:5] with BASE_ADDR[31:5].
REQ-028 SHALL give edge latency: src rising before edge k, PEND set at edge k+2, irq high in the following cycle.
REQ-029 SHALL treat rd and wr asserted in the same cycle as wr only.

Reset
REQ-030 SHALL, while reset=0, clear synchronizers, PEND, MASK, MODE (all level), and INSVC asynchronously; irq=0, rdata=0.
REQ-031 SHALL resume from the all-zero state on the first edge after reset release; a src held high then sets level PEND two cycles later.
REQ-032 SHALL discard an in-progress claim (INSVC) when reset asserts mid-service.

Verification
REQ-033 Reset release, MASK=0xF, MODE=0, src=4'b0100 -> PEND=0x4 at edge +2, irq=1, CLAIM reads 3.
REQ-034 MODE=0xF, MASK=0xF, pulse src[1] and src[3] one cycle -> PEND=0xA, CLAIM read returns 2, INSVC=2, PEND=0x8, irq=0 until EOI, then irq=1 and CLAIM returns 4.
REQ-035 Edge mode, wr PEND=0x1 in the same cycle a new src[0] edge is detected -> PEND[0] remains 1.
REQ-036 kmode=1 with ACT=0x2 -> irq=0; kmode drops to 0 -> irq=1 same cycle.
REQ-037 MASK=0, src=0xF level -> CLAIM reads 0, irq=0, INSVC stays 0; rd at BASE_ADDR+0x40 -> rdata=0.
REQ-038 N_SRC=16 build, src[15] edge only, MASK=0xFFFF, MODE=0xFFFF -> CLAIM returns 16, EOI then PEND=0, irq=0.

Source files
------------

// File: rtl/intr_ctrl.sv
// intr_ctrl: N_SRC-source interrupt controller with a 32-byte register window.
// Latency: an src edge sets PEND two edges after it is first sampled; irq is combinational from registered state.
// Backpressure: none; every rd/wr strobe completes in its own cycle, and rdata is valid in that same cycle.
//
// Ports:
//   sysclk, reset      - rising-edge clock; asynchronous active-low reset
//   rd, wr, addr       - single-cycle bus strobes and byte address (wr wins when both are set)
//   wdata, rdata       - write data; combinational read data (zero when not selected)
//   src                - asynchronous interrupt request lines
//   kmode              - CPU is in kernel mode, which masks irq
//   irq                - interrupt request to the CPU
//
// Register map (byte offsets): 0x00 PEND (W1C, edge bits), 0x04 MASK, 0x08 MODE (1 = edge),
// 0x0C CLAIM (read claims the winner), 0x10 EOI (write ends service), 0x14 INSVC (read only).
module intr_ctrl #(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h40000040
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             rd,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [N_SRC-1:0] src,
    input  logic             kmode,
    output logic             irq
);

    localparam logic [2:0] OFF_PEND  = 3'd0;
    localparam logic [2:0] OFF_MASK  = 3'd1;
    localparam logic [2:0] OFF_MODE  = 3'd2;
    localparam logic [2:0] OFF_CLAIM = 3'd3;
    localparam logic [2:0] OFF_EOI   = 3'd4;
    localparam logic [2:0] OFF_INSVC = 3'd5;

    logic [N_SRC-1:0] s1_q, s2_q, s3_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [4:0]       insvc_q, insvc_d;

    logic             hit;
    logic [2:0]       off;
    logic             wr_hit, rd_hit;
    logic [N_SRC-1:0] act;
    logic [N_SRC-1:0] win_oh;
    logic [4:0]       claim_id;
    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] wd;
    logic             claim_take;
    logic             unused_bits;

    assign hit         = (addr[31:5] == BASE_ADDR[31:5]);
    assign off         = addr[4:2];
    assign wr_hit      = wr & hit;
    // A read strobe coinciding with a write is treated as the write alone.
    assign rd_hit      = rd & ~wr & hit;
    assign wd          = wdata[N_SRC-1:0];
    assign unused_bits = ^{addr[1:0], wdata};

    assign act      = pend_q & mask_q;
    assign edge_det = s2_q & ~s3_q;

    // Lowest index wins; iterate downward so the last assignment is the lowest set bit.
    always_comb begin
        claim_id = '0;
        win_oh   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                claim_id  = 5'(i + 1);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    assign claim_take = rd_hit && (off == OFF_CLAIM) && (claim_id != 5'd0) && (insvc_q == 5'd0);

    always_comb begin
        mask_d  = mask_q;
        mode_d  = mode_q;
        insvc_d = insvc_q;
        clr     = '0;

        if (claim_take) begin
            insvc_d = claim_id;
            clr     = win_oh;
        end

        if (wr_hit) begin
            case (off)
                OFF_PEND: clr     = wd;
                OFF_MASK: mask_d  = wd;
                OFF_MODE: mode_d  = wd;
                OFF_EOI:  insvc_d = 5'd0;
                default:  ;
            endcase
        end

        // Edge bits: sticky, cleared by W1C/claim, but a fresh edge in the same cycle wins.
        // Level bits: track the synchronized input, so clears are irrelevant.
        pend_d = (mode_q & ((pend_q & ~clr) | edge_det)) | (~mode_q & s2_q);

        // A source whose mode is being switched starts clean under its new mode.
        if (wr_hit && (off == OFF_MODE)) begin
            pend_d = pend_d & ~(wd ^ mode_q);
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            insvc_q <= '0;
        end else begin
            s1_q    <= src;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            insvc_q <= insvc_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_hit) begin
            case (off)
                OFF_PEND:  rdata = 32'(pend_q);
                OFF_MASK:  rdata = 32'(mask_q);
                OFF_MODE:  rdata = 32'(mode_q);
                OFF_CLAIM: rdata = 32'(claim_id);
                OFF_INSVC: rdata = 32'(insvc_q);
                default:   rdata = '0;
            endcase
        end
    end

    assign irq = (|act) & (insvc_q == 5'd0) & ~kmode;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    localparam logic [31:0] BASE = 32'h40000040;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic        rd     = 1'b0;
    logic        wr     = 1'b0;
    logic        kmode  = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [3:0]  src    = '0;
    logic [15:0] src16  = '0;
    logic [31:0] rdata, rdata16;
    logic        irq, irq16;

    int n_cmp = 0;
    int n_err = 0;

    intr_ctrl #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
        .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .src(src), .kmode(kmode), .irq(irq)
    );

    intr_ctrl #(.N_SRC(16), .BASE_ADDR(BASE)) dut16 (
        .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata16), .src(src16), .kmode(kmode), .irq(irq16)
    );

    always #5 sysclk = ~sysclk;

    // Reference model of the 4-source instance: register contents plus a history of sampled src.
    logic [3:0] m_pend, m_mask, m_mode;
    int         m_insvc;
    logic [3:0] m_hist [0:3];

    task automatic model_clear();
        m_pend = '0; m_mask = '0; m_mode = '0; m_insvc = 0;
        for (int i = 0; i < 4; i++) m_hist[i] = '0;
    endtask

    function automatic int m_claim();
        logic [3:0] a;
        a = m_pend & m_mask;
        for (int i = 0; i < 4; i++) if (a[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic r, input logic w, input logic [31:0] a);
        if (!r || w || (a[31:5] != BASE[31:5])) return 32'h0;
        case (a[4:2])
            3'd0:    return {28'h0, m_pend};
            3'd1:    return {28'h0, m_mask};
            3'd2:    return {28'h0, m_mode};
            3'd3:    return 32'(m_claim());
            3'd5:    return 32'(m_insvc);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_irq();
        return ((m_pend & m_mask) != 4'h0) && (m_insvc == 0) && !kmode;
    endfunction

    // Applies one clock edge's worth of rules to the model using the inputs present at that edge.
    task automatic model_step();
        logic [3:0] s2, s3, np, nm, nd;
        int         ni, w;
        logic       inwin;
        if (!reset) begin
            model_clear();
            return;
        end
        s2 = m_hist[1];          // value sampled two edges ago
        s3 = m_hist[2];          // value sampled three edges ago
        inwin = (addr[31:5] == BASE[31:5]);
        w  = m_claim();
        np = m_pend; nm = m_mask; nd = m_mode; ni = m_insvc;
        if (rd && !wr && inwin && addr[4:2] == 3'd3 && w != 0 && m_insvc == 0) begin
            ni = w;
            np[w-1] = 1'b0;
        end
        if (wr && inwin) begin
            case (addr[4:2])
                3'd0: np = np & ~wdata[3:0];
                3'd1: nm = wdata[3:0];
                3'd2: nd = wdata[3:0];
                3'd4: ni = 0;
                default: ;
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            if (m_mode[i]) np[i] = np[i] | (s2[i] & ~s3[i]);
            else           np[i] = s2[i];
        end
        if (wr && inwin && addr[4:2] == 3'd2)
            for (int i = 0; i < 4; i++) if (wdata[i] != m_mode[i]) np[i] = 1'b0;
        m_pend = np; m_mask = nm; m_mode = nd; m_insvc = ni;
        m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = src;
    endtask

    task automatic tick();
        @(posedge sysclk);
        model_step();
        @(negedge sysclk);
    endtask

    task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
        addr = BASE + off; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_setup(input logic [31:0] off);
        addr = BASE + off; rd = 1'b1;
        #1;
    endtask

    task automatic quiesce();
        rd = 1'b0; wr = 1'b0; src = '0; src16 = '0; kmode = 1'b0;
        repeat (4) tick();
        wr_reg(32'h10, 32'h0);
        wr_reg(32'h08, 32'h0);
        wr_reg(32'h04, 32'h0);
    endtask

    task automatic test_reset();
        src = 4'b0100; reset = 1'b0; kmode = 1'b0;
        model_clear();
        repeat (2) tick();
        rd_setup(32'h00);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", rdata); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b want 0", irq); end
        rd = 1'b0;
        reset = 1'b1;
        wr_reg(32'h04, 32'hF);            // first edge after release
        rd_setup(32'h00);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL pend_e1 got %h want 0", rdata); end
        tick();
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL pend_e2 got %h want 0", rdata); end
        tick();
        n_cmp++; if (rdata !== 32'h4) begin n_err++; $display("FAIL pend_e3 got %h want 4", rdata); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL level_irq got %b want 1", irq); end
        rd_setup(32'h0C);
        n_cmp++; if (rdata !== 32'h3) begin n_err++; $display("FAIL level_claim got %h want 3", rdata); end
        rd_setup(32'h14);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_insvc got %h want 0", rdata); end
        rd = 1'b0;
    endtask

    task automatic test_edge_claim();
        quiesce();
        wr_reg(32'h08, 32'hF);
        wr_reg(32'h04, 32'hF);
        src = 4'b1010; tick(); src = 4'b0000;
        repeat (3) tick();
        rd_setup(32'h00);
        n_cmp++; if (rdata !== 32'hA) begin n_err++; $display("FAIL edge_pend got %h want a", rdata); end
        rd_setup(32'h0C);
        n_cmp++; if (rdata !== 32'h2) begin n_err++; $display("FAIL edge_claim got %h want 2", rdata); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL edge_irq_pre got %b want 1", irq); end
        tick();
        rd_setup(32'h14);
        n_cmp++; if (rdata !== 32'h2) begin n_err++; $display("FAIL edge_insvc got %h want 2", rdata); end
        rd_setup(32'h00);
        n_cmp++; if (rdata !== 32'h8) begin n_err++; $display("FAIL edge_pend_post got %h want 8", rdata); end
        rd = 1'b0;
        repeat (3) tick();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL insvc_irq got %b want 0", irq); end
        rd_setup(32'h0C);
        tick();                            // claim while in service must not change state
        rd_setup(32'h14);
        n_cmp++; if (rdata !== 32'h2) begin n_err++; $display("FAIL reclaim_insvc got %h want 2", rdata); end
        rd = 1'b0;
        wr_reg(32'h10, $urandom);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL eoi_irq got %b want 1", irq); end
        rd_setup(32'h0C);
        n_cmp++; if (rdata !== 32'h4) begin n_err++; $display("FAIL eoi_claim got %h want 4", rdata); end
        rd = 1'b0;
    endtask

    task automatic test_reset_midservice();
        rd_setup(32'h0C);
        tick();
        rd_setup(32'h14);
        n_cmp++; if (rdata !== 32'h4) begin n_err++; $display("FAIL svc_before got %h want 4", rdata); end
        reset = 1'b0;
        model_clear();
        #1;
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL svc_async got %h want 0", rdata); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL svc_rst_irq got %b want 0", irq); end
        rd = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        rd_setup(32'h14);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL svc_after got %h want 0", rdata); end
        rd = 1'b0;
    endtask

    task automatic test_w1c_race();
        quiesce();
        wr_reg(32'h08, 32'hF);
        src = 4'b0001;
        tick(); tick();                    // edge now visible to PEND logic
        wr_reg(32'h00, 32'h1);
        rd_setup(32'h00);
        n_cmp++; if (rdata !== 32'h1) begin n_err++; $display("FAIL w1c_race got %h want 1", rdata); end
        rd = 1'b0;
        wr_reg(32'h00, 32'h1);
        rd_setup(32'h00);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL w1c_clear got %h want 0", rdata); end
        rd = 1'b0;
        wr_reg(32'h08, 32'h0);
        tick();
        wr_reg(32'h00, 32'hF);
        rd_setup(32'h00);
        n_cmp++; if (rdata !== 32'h1) begin n_err++; $display("FAIL w1c_level got %h want 1", rdata); end
        rd = 1'b0;
    endtask

    task automatic test_kmode();
        quiesce();
        wr_reg(32'h08, 32'hF);
        wr_reg(32'h04, 32'hF);
        src = 4'b0010; tick(); src = 4'b0000;
        repeat (3) tick();
        kmode = 1'b1; #1;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL kmode_hi got %b want 0", irq); end
        kmode = 1'b0; #1;
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL kmode_lo got %b want 1", irq); end
    endtask

    task automatic test_masked();
        quiesce();
        src = 4'hF;
        repeat (4) tick();
        rd_setup(32'h0C);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL mask_claim got %h want 0", rdata); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_irq got %b want 0", irq); end
        tick();
        rd_setup(32'h14);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL mask_insvc got %h want 0", rdata); end
        rd_setup(32'h40);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL outside_rd got %h want 0", rdata); end
        rd_setup(32'h18);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL hole_rd got %h want 0", rdata); end
        rd_setup(32'h00);
        n_cmp++; if (rdata !== 32'hF) begin n_err++; $display("FAIL mask_pend got %h want f", rdata); end
        addr = BASE + 32'h04; wdata = 32'h3; wr = 1'b1; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rdwr_rdata got %h want 0", rdata); end
        tick();
        wr = 1'b0; rd = 1'b0;
        wr_reg(32'h44, 32'hF);             // aliases MASK offset but lies outside the window
        wr_reg(32'h14, 32'hF);             // INSVC is read-only
        rd_setup(32'h04);
        n_cmp++; if (rdata !== 32'h3) begin n_err++; $display("FAIL rdwr_mask got %h want 3", rdata); end
        rd_setup(32'h14);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL ro_insvc got %h want 0", rdata); end
        rd = 1'b0;
    endtask

    task automatic test_random();
        int op;
        logic [31:0] off;
        quiesce();
        for (int n = 0; n < 600; n++) begin
            src   = 4'($urandom);
            kmode = ($urandom_range(0, 3) == 0);
            op    = $urandom_range(0, 5);
            off   = 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 15) == 0) off = off + 32'h20;
            addr  = BASE + off;
            wdata = $urandom;
            rd    = (op == 1 || op == 2 || op == 5);
            wr    = (op == 3 || op == 4 || op == 5);
            #1;
            n_cmp++;
            if (rdata !== m_read(rd, wr, addr)) begin
                n_err++; $display("FAIL rand_rdata cyc %0d off %h got %h want %h", n, off, rdata, m_read(rd, wr, addr));
            end
            n_cmp++;
            if (irq !== m_irq()) begin
                n_err++; $display("FAIL rand_irq cyc %0d got %b want %b", n, irq, m_irq());
            end
            tick();
            rd = 1'b0; wr = 1'b0;
        end
    endtask

    task automatic test_n16();
        quiesce();
        wr_reg(32'h04, 32'hFFFF);
        wr_reg(32'h08, 32'hFFFF);
        src16 = 16'h8000; tick(); src16 = 16'h0;
        repeat (3) tick();
        n_cmp++; if (irq16 !== 1'b1) begin n_err++; $display("FAIL n16_irq got %b want 1", irq16); end
        rd_setup(32'h0C);
        n_cmp++; if (rdata16 !== 32'd16) begin n_err++; $display("FAIL n16_claim got %h want 10", rdata16); end
        tick();
        rd_setup(32'h14);
        n_cmp++; if (rdata16 !== 32'd16) begin n_err++; $display("FAIL n16_insvc got %h want 10", rdata16); end
        rd = 1'b0;
        wr_reg(32'h10, 32'h0);
        rd_setup(32'h00);
        n_cmp++; if (rdata16 !== 32'h0) begin n_err++; $display("FAIL n16_pend got %h want 0", rdata16); end
        n_cmp++; if (irq16 !== 1'b0) begin n_err++; $display("FAIL n16_irq_end got %b want 0", irq16); end
        rd = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_edge_claim();
        test_reset_midservice();
        test_w1c_race();
        test_kmode();
        test_masked();
        test_random();
        test_n16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
